// File: rtl/iob_cache_fe_arbiter_pkg.sv
// Shared types and helpers for the iob_cache frontend arbiter.
package iob_cache_fe_arbiter_pkg;

    // Arbiter FSM states: IDLE waits for a request, BUSY holds it until the cache acks
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Round-robin successor. The compare wraps correctly when n is not a power of two.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/iob_cache_fe_arbiter_rr_prio.sv
// Rotate-priority encoder: the first set request at or after ptr_i, wrapping mod N_REQ.
module iob_cache_fe_arbiter_rr_prio #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic                     valid_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W:0]   w_cand;
    logic [IDX_W-1:0] w_pos;

    // Scan from the farthest offset down, so the request closest to ptr_i is written last and wins
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        w_cand  = '0;
        w_pos   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_cand = {1'b0, ptr_i} + (IDX_W + 1)'(i);
            if (w_cand >= (IDX_W + 1)'(N_REQ)) begin
                w_cand = w_cand - (IDX_W + 1)'(N_REQ);
            end
            w_pos = w_cand[IDX_W-1:0];
            if (req_i[w_pos]) begin
                valid_o = 1'b1;
                idx_o   = w_pos;
            end
        end
    end

endmodule

// File: rtl/iob_cache_fe_arbiter.sv
// Round-robin arbiter that shares one iob_cache native frontend between N_REQ requesters.
// It latches the winning request, holds it on the cache port until ack, and
// routes ack/rdata back to the winner only.
module iob_cache_fe_arbiter
    import iob_cache_fe_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic                         clk_i,
    input  logic                         arst_n_i,
    input  logic [N_REQ-1:0]             s_avalid_i,
    input  logic [N_REQ*ADDR_W-1:0]      s_addr_i,
    input  logic [N_REQ*DATA_W-1:0]      s_wdata_i,
    input  logic [N_REQ*(DATA_W/8)-1:0]  s_wstrb_i,
    output logic [DATA_W-1:0]            s_rdata_o,
    output logic [N_REQ-1:0]             s_ack_o,
    output logic                         m_avalid_o,
    output logic [ADDR_W-1:0]            m_addr_o,
    output logic [DATA_W-1:0]            m_wdata_o,
    output logic [DATA_W/8-1:0]          m_wstrb_o,
    input  logic [DATA_W-1:0]            m_rdata_i,
    input  logic                         m_ack_i,
    output logic [$clog2(N_REQ)-1:0]     grant_o,
    output logic                         busy_o
);
    localparam int IDX_W  = $clog2(N_REQ);
    localparam int STRB_W = DATA_W / 8;

    arb_state_t        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_grant;
    logic              r_avalid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;

    logic              w_valid;
    logic [IDX_W-1:0]  w_idx;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [STRB_W-1:0] w_sel_wstrb;

    iob_cache_fe_arbiter_rr_prio #(
        .N_REQ (N_REQ)
    ) u_rr_prio (
        .req_i   (s_avalid_i),
        .ptr_i   (r_ptr),
        .valid_o (w_valid),
        .idx_o   (w_idx)
    );

    // Select the winning requester's fields out of the flattened buses
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_idx == IDX_W'(k)) begin
                w_sel_addr  = s_addr_i[k*ADDR_W +: ADDR_W];
                w_sel_wdata = s_wdata_i[k*DATA_W +: DATA_W];
                w_sel_wstrb = s_wstrb_i[k*STRB_W +: STRB_W];
            end
        end
    end

    // Arbitration FSM: grant and latch in IDLE, hold the request until the cache acks in BUSY
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_avalid <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant  <= w_idx;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        r_wstrb  <= w_sel_wstrb;
                        r_avalid <= 1'b1;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (m_ack_i) begin
                        r_avalid <= 1'b0;
                        r_ptr    <= IDX_W'(rr_next(int'(r_grant), N_REQ));
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Route the cache ack to the granted requester only; acks seen in IDLE are dropped
    always_comb begin
        s_ack_o = '0;
        if (r_state == ST_BUSY) begin
            s_ack_o[r_grant] = m_ack_i;
        end
    end

    assign s_rdata_o  = m_rdata_i;
    assign m_avalid_o = r_avalid;
    assign m_addr_o   = r_addr;
    assign m_wdata_o  = r_wdata;
    assign m_wstrb_o  = r_wstrb;
    assign grant_o    = r_grant;
    assign busy_o     = (r_state == ST_BUSY);

endmodule

// File: tb/tb_iob_cache_fe_arbiter.sv
// Directed bench for iob_cache_fe_arbiter: a 2-requester instance for the main
// behaviour and a 3-requester instance for the non-power-of-two pointer wrap.
module tb_iob_cache_fe_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // DUT A: N_REQ = 2
    logic [1:0]  a_avalid;
    logic [47:0] a_addr;
    logic [63:0] a_wdata;
    logic [7:0]  a_wstrb;
    logic [31:0] a_rdata;
    logic [1:0]  a_ack;
    logic        a_m_avalid;
    logic [23:0] a_m_addr;
    logic [31:0] a_m_wdata;
    logic [3:0]  a_m_wstrb;
    logic [31:0] a_m_rdata;
    logic        a_m_ack;
    logic [0:0]  a_grant;
    logic        a_busy;

    // DUT B: N_REQ = 3
    logic [2:0]  b_avalid;
    logic [71:0] b_addr;
    logic [95:0] b_wdata;
    logic [11:0] b_wstrb;
    logic [31:0] b_rdata;
    logic [2:0]  b_ack;
    logic        b_m_avalid;
    logic [23:0] b_m_addr;
    logic [31:0] b_m_wdata;
    logic [3:0]  b_m_wstrb;
    logic [31:0] b_m_rdata;
    logic        b_m_ack;
    logic [1:0]  b_grant;
    logic        b_busy;

    logic [31:0] mem [0:255];
    logic [2:0]  ack_seen;
    logic [31:0] rdata_seen;

    iob_cache_fe_arbiter #(.N_REQ(2), .ADDR_W(24), .DATA_W(32)) u_dut_a (
        .clk_i      (clk),
        .arst_n_i   (rst_n),
        .s_avalid_i (a_avalid),
        .s_addr_i   (a_addr),
        .s_wdata_i  (a_wdata),
        .s_wstrb_i  (a_wstrb),
        .s_rdata_o  (a_rdata),
        .s_ack_o    (a_ack),
        .m_avalid_o (a_m_avalid),
        .m_addr_o   (a_m_addr),
        .m_wdata_o  (a_m_wdata),
        .m_wstrb_o  (a_m_wstrb),
        .m_rdata_i  (a_m_rdata),
        .m_ack_i    (a_m_ack),
        .grant_o    (a_grant),
        .busy_o     (a_busy)
    );

    iob_cache_fe_arbiter #(.N_REQ(3), .ADDR_W(24), .DATA_W(32)) u_dut_b (
        .clk_i      (clk),
        .arst_n_i   (rst_n),
        .s_avalid_i (b_avalid),
        .s_addr_i   (b_addr),
        .s_wdata_i  (b_wdata),
        .s_wstrb_i  (b_wstrb),
        .s_rdata_o  (b_rdata),
        .s_ack_o    (b_ack),
        .m_avalid_o (b_m_avalid),
        .m_addr_o   (b_m_addr),
        .m_wdata_o  (b_m_wdata),
        .m_wstrb_o  (b_m_wstrb),
        .m_rdata_i  (b_m_rdata),
        .m_ack_i    (b_m_ack),
        .grant_o    (b_grant),
        .busy_o     (b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int k, input logic v, input logic [23:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        a_avalid[k]          = v;
        a_addr[k*24 +: 24]   = addr;
        a_wdata[k*32 +: 32]  = wdata;
        a_wstrb[k*4 +: 4]    = wstrb;
    endtask

    task automatic set_b(input int k, input logic v, input logic [23:0] addr);
        b_avalid[k]          = v;
        b_addr[k*24 +: 24]   = addr;
        b_wdata[k*32 +: 32]  = '0;
        b_wstrb[k*4 +: 4]    = '0;
    endtask

    // Cache model for DUT A: one-word memory access, ack this cycle, sample the demuxed response
    task automatic ack_cycle_a();
        if (a_m_wstrb != 4'h0) mem[a_m_addr[7:0]] = a_m_wdata;
        a_m_rdata = mem[a_m_addr[7:0]];
        a_m_ack   = 1'b1;
        #1;
        ack_seen   = {1'b0, a_ack};
        rdata_seen = a_rdata;
        tick();
        a_m_ack = 1'b0;
    endtask

    task automatic ack_cycle_b();
        b_m_rdata = 32'hB0B0_0000 | {8'h0, b_m_addr};
        b_m_ack   = 1'b1;
        #1;
        ack_seen   = b_ack;
        rdata_seen = b_rdata;
        tick();
        b_m_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        a_avalid  = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        a_m_rdata = '0; a_m_ack = 1'b0;
        b_avalid  = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
        b_m_rdata = '0; b_m_ack = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ack_seen = '0; rdata_seen = '0;

        repeat (2) tick();
        chk("rst_m_avalid", 64'(a_m_avalid), 64'd0);
        chk("rst_s_ack",    64'(a_ack),      64'd0);
        chk("rst_busy",     64'(a_busy),     64'd0);
        chk("rst_grant",    64'(a_grant),    64'd0);
        chk("rst_m_addr",   64'(a_m_addr),   64'd0);
        chk("rst_m_wstrb",  64'(a_m_wstrb),  64'd0);
        rst_n = 1'b1;
        tick();

        // Single write from req0
        set_a(0, 1'b1, 24'h3, 32'h9, 4'hF);
        #1;
        chk("wr_latency", 64'(a_m_avalid), 64'd0);
        tick();
        chk("wr_m_avalid", 64'(a_m_avalid), 64'd1);
        chk("wr_m_addr",   64'(a_m_addr),   64'h3);
        chk("wr_m_wdata",  64'(a_m_wdata),  64'h9);
        chk("wr_m_wstrb",  64'(a_m_wstrb),  64'hF);
        chk("wr_busy",     64'(a_busy),     64'd1);
        chk("wr_grant",    64'(a_grant),    64'd0);
        ack_cycle_a();
        chk("wr_ack", 64'(ack_seen), 64'b01);
        set_a(0, 1'b0, 24'h0, 32'h0, 4'h0);
        chk("wr_done_avalid", 64'(a_m_avalid), 64'd0);
        chk("wr_done_busy",   64'(a_busy),     64'd0);

        // Cache ack while idle is ignored
        a_m_ack = 1'b1;
        #1;
        chk("idle_ack", 64'(a_ack), 64'd0);
        tick();
        chk("idle_ack_busy", 64'(a_busy), 64'd0);
        a_m_ack = 1'b0;

        // Read back addr 3
        set_a(0, 1'b1, 24'h3, 32'h0, 4'h0);
        tick();
        chk("rd_m_wstrb", 64'(a_m_wstrb), 64'h0);
        ack_cycle_a();
        chk("rd_ack",   64'(ack_seen),   64'b01);
        chk("rd_rdata", 64'(rdata_seen), 64'h9);
        set_a(0, 1'b0, 24'h0, 32'h0, 4'h0);

        // Simultaneous reads straight out of reset: ptr=0 so req0 goes first
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        set_a(0, 1'b1, 24'h10, 32'h0, 4'h0);
        set_a(1, 1'b1, 24'h20, 32'h0, 4'h0);
        tick();
        chk("sim_grant0", 64'(a_grant),  64'd0);
        chk("sim_addr0",  64'(a_m_addr), 64'h10);
        ack_cycle_a();
        chk("sim_ack0", 64'(ack_seen), 64'b01);
        set_a(0, 1'b0, 24'h0, 32'h0, 4'h0);
        chk("b2b_idle_gap", 64'(a_m_avalid), 64'd0);
        tick();
        chk("sim_grant1", 64'(a_grant),  64'd1);
        chk("sim_addr1",  64'(a_m_addr), 64'h20);
        ack_cycle_a();
        chk("sim_ack1", 64'(ack_seen), 64'b10);
        set_a(1, 1'b0, 24'h0, 32'h0, 4'h0);

        // Fairness with both requesters held continuously (ptr back at 0)
        set_a(0, 1'b1, 24'h30, 32'h0, 4'h0);
        set_a(1, 1'b1, 24'h31, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("fair_grant%0d", i), 64'(a_grant), 64'(i % 2));
            ack_cycle_a();
            chk($sformatf("fair_ack%0d", i), 64'(ack_seen), (i % 2 == 0) ? 64'b01 : 64'b10);
        end
        set_a(0, 1'b0, 24'h0, 32'h0, 4'h0);
        set_a(1, 1'b0, 24'h0, 32'h0, 4'h0);
        tick();

        // Hold stability: req1 changes addr, then drops avalid, mid-BUSY
        set_a(1, 1'b1, 24'h12, 32'h0, 4'h0);
        tick();
        chk("hold_grant", 64'(a_grant),  64'd1);
        chk("hold_addr0", 64'(a_m_addr), 64'h12);
        set_a(1, 1'b1, 24'h55, 32'h0, 4'h0);
        tick();
        chk("hold_addr1", 64'(a_m_addr), 64'h12);
        set_a(1, 1'b0, 24'h55, 32'h0, 4'h0);
        tick();
        chk("hold_addr2", 64'(a_m_addr), 64'h12);
        chk("hold_busy",  64'(a_busy),   64'd1);
        ack_cycle_a();
        chk("hold_ack", 64'(ack_seen), 64'b10);

        // Reset mid-BUSY after ptr has been advanced to 1
        set_a(0, 1'b1, 24'h5, 32'h0, 4'h0);
        tick();
        ack_cycle_a();
        set_a(0, 1'b0, 24'h0, 32'h0, 4'h0);
        set_a(1, 1'b1, 24'h6, 32'h0, 4'h0);
        tick();
        chk("rstb_grant", 64'(a_grant), 64'd1);
        a_m_ack = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("rstb_m_avalid", 64'(a_m_avalid), 64'd0);
        chk("rstb_s_ack",    64'(a_ack),      64'd0);
        chk("rstb_busy",     64'(a_busy),     64'd0);
        a_m_ack = 1'b0;
        set_a(1, 1'b0, 24'h0, 32'h0, 4'h0);
        tick();
        rst_n = 1'b1;
        tick();
        set_a(0, 1'b1, 24'h7, 32'h0, 4'h0);
        set_a(1, 1'b1, 24'h8, 32'h0, 4'h0);
        tick();
        chk("post_rst_grant", 64'(a_grant),  64'd0);
        chk("post_rst_addr",  64'(a_m_addr), 64'h7);
        ack_cycle_a();
        set_a(0, 1'b0, 24'h0, 32'h0, 4'h0);
        set_a(1, 1'b0, 24'h0, 32'h0, 4'h0);
        tick();

        // N_REQ=3 wrap: serve req1 to move ptr to 2, then req0 and req1 together
        set_b(1, 1'b1, 24'h11);
        tick();
        chk("w3_first_grant", 64'(b_grant), 64'd1);
        ack_cycle_b();
        chk("w3_first_ack", 64'(ack_seen), 64'b010);
        set_b(1, 1'b0, 24'h0);
        tick();
        set_b(0, 1'b1, 24'h20);
        set_b(1, 1'b1, 24'h21);
        tick();
        chk("w3_wrap_grant", 64'(b_grant),  64'd0);
        chk("w3_wrap_addr",  64'(b_m_addr), 64'h20);
        ack_cycle_b();
        chk("w3_wrap_ack",   64'(ack_seen),   64'b001);
        chk("w3_wrap_rdata", 64'(rdata_seen), 64'hB0B0_0020);
        tick();
        chk("w3_next_grant", 64'(b_grant),  64'd1);
        chk("w3_next_addr",  64'(b_m_addr), 64'h21);
        ack_cycle_b();
        chk("w3_next_ack", 64'(ack_seen), 64'b010);
        set_b(0, 1'b0, 24'h0);
        set_b(1, 1'b0, 24'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
